counter_down_reload: RTL and testbench

Loadable down-counter/timer. It is the counting-direction counterpart of the team's 4-bit up counter. It counts from a loaded value down to zero, then either stops (one-shot) or reloads (periodic). It emits a one-cycle terminal-count pulse on reaching zero. It is used as a delay/interval timer alongside the up counter in the basics_sequential set.

---
 rtl/counter_down_reload.sv | 78 +++++++
 tb/tb_counter_down_reload.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_down_reload.sv
// Loadable down-counter/timer: counts a loaded value down to zero, then stops
// (one-shot) or reloads (periodic), pulsing tc on the cycle count reaches zero.
module counter_down_reload #(
  parameter int unsigned           WIDTH      = 4,
  parameter logic [WIDTH-1:0]      INIT_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= INIT_VALUE;
      reload_reg <= INIT_VALUE;
      tc         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
      busy       <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
    end
  end

  // Next-state logic: load beats counting; zero either reloads or expires.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    if (load) begin
      count_nxt  = load_value;
      reload_nxt = load_value;
      state_nxt  = IDLE;
    end else if (enable && (state != DONE)) begin
      if (count != '0) begin
        count_nxt = count - WIDTH'(1);
        state_nxt = RUN;
        tc_nxt    = (count == WIDTH'(1));
      end else if (auto_reload && (reload_reg != '0)) begin
        count_nxt = reload_reg;
        state_nxt = RUN;
      end else begin
        state_nxt = DONE;
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: tb/tb_counter_down_reload.sv
// Self-checking bench for counter_down_reload: directed scenarios plus random
// stimulus, compared every cycle against a behavioural timer model.
module tb_counter_down_reload;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] load_value;
  logic       auto_reload;
  logic [3:0] count;
  logic       zero;
  logic       tc;
  logic       busy;
  logic       done;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;

  // Model: remaining ticks, period value, phase (0 loaded, 1 running, 2 expired)
  int m_left;
  int m_period;
  int m_phase;
  int m_tc;

  counter_down_reload #(.WIDTH(4), .INIT_VALUE(4'd15)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .auto_reload(auto_reload),
    .count(count), .zero(zero), .tc(tc), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural reference: one tick of the timer per rising edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_left = 15; m_period = 15; m_phase = 0; m_tc = 0;
    end else if (load) begin
      m_left = int'(load_value); m_period = int'(load_value); m_phase = 0; m_tc = 0;
    end else if (enable && m_phase != 2) begin
      if (m_left > 0) begin
        m_left = m_left - 1;
        m_phase = 1;
        m_tc = (m_left == 0) ? 1 : 0;
      end else begin
        m_tc = 0;
        if (auto_reload && m_period != 0) begin
          m_left = m_period; m_phase = 1;
        end else begin
          m_phase = 2;
        end
      end
    end else begin
      m_tc = 0;
    end
  end

  // Cycle-by-cycle comparison, sampled mid-cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      check("count", int'(count), m_left);
      check("zero", int'(zero), (m_left == 0) ? 1 : 0);
      check("tc", int'(tc), m_tc);
      check("busy", int'(busy), (m_phase == 1) ? 1 : 0);
      check("done", int'(done), (m_phase == 2) ? 1 : 0);
    end
  end

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit l, input logic [3:0] lv, input bit en, input bit ar);
    load = l; load_value = lv; enable = en; auto_reload = ar;
  endtask

  initial begin
    int exp_seq [8];
    reset = 1'b1;
    drive(0, 4'd0, 0, 0);

    // Asynchronous reset between edges
    #5 reset = 1'b0;
    #1;
    check("rst_count", int'(count), 15);
    check("rst_tc", int'(tc), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_zero", int'(zero), 0);
    edge1();
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (5) begin
      edge1();
      check("idle_hold", int'(count), 15);
    end

    // One-shot from 5
    drive(1, 4'd5, 0, 0);
    edge1();
    check("os_load", int'(count), 5);
    drive(0, 4'd0, 1, 0);
    for (int i = 4; i >= 0; i--) begin
      edge1();
      check("os_count", int'(count), i);
      check("os_tc", int'(tc), (i == 0) ? 1 : 0);
    end
    edge1();
    check("os_done", int'(done), 1);
    check("os_busy", int'(busy), 0);
    repeat (10) begin
      edge1();
      check("os_hold", int'(count), 0);
    end

    // Periodic with reload 3 (load beats enable on the same edge)
    drive(1, 4'd3, 1, 1);
    edge1();
    check("per_load", int'(count), 3);
    drive(0, 4'd0, 1, 1);
    exp_seq = '{2, 1, 0, 3, 2, 1, 0, 3};
    for (int i = 0; i < 8; i++) begin
      edge1();
      check("per_count", int'(count), exp_seq[i]);
      check("per_tc", int'(tc), (exp_seq[i] == 0) ? 1 : 0);
      check("per_done", int'(done), 0);
    end

    // Pause at 7, then load+enable priority
    drive(1, 4'd10, 0, 0);
    edge1();
    drive(0, 4'd0, 1, 0);
    repeat (3) edge1();
    check("pause_pre", int'(count), 7);
    drive(0, 4'd0, 0, 0);
    repeat (3) begin
      edge1();
      check("pause_count", int'(count), 7);
      check("pause_busy", int'(busy), 1);
      check("pause_tc", int'(tc), 0);
    end
    drive(1, 4'd9, 1, 0);
    edge1();
    check("prio_count", int'(count), 9);
    check("prio_busy", int'(busy), 0);

    // Reset mid-run
    drive(1, 4'd8, 0, 1);
    edge1();
    drive(0, 4'd0, 1, 1);
    edge1();
    edge1();
    check("mid_pre", int'(count), 6);
    #4 reset = 1'b0;
    #1;
    check("mid_rst_count", int'(count), 15);
    check("mid_rst_tc", int'(tc), 0);
    check("mid_rst_busy", int'(busy), 0);
    #2 reset = 1'b1;
    drive(0, 4'd0, 1, 0);
    edge1();
    check("post_rst1", int'(count), 14);
    edge1();
    check("post_rst2", int'(count), 13);

    // Zero load, one-shot then periodic
    for (int m = 0; m < 2; m++) begin
      drive(1, 4'd0, 0, m[0]);
      edge1();
      check("zl_zero", int'(zero), 1);
      drive(0, 4'd0, 1, m[0]);
      edge1();
      check("zl_done", int'(done), 1);
      check("zl_tc", int'(tc), 0);
      edge1();
      check("zl_tc2", int'(tc), 0);
    end

    // Random stimulus against the model
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) begin
        #3 reset = 1'b0;
        #3 reset = 1'b1;
      end
      edge1();
    end

    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
